// File: rtl/mem_map_pkg.sv
// Shared types and constants for the CPU data-port memory-map controller.
package mem_map_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_IO, REG_ROM, REG_NONE} region_t;
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [2:0] IO_SW   = 3'd0;
  localparam logic [2:0] IO_GPIO = 3'd1;
  localparam logic [2:0] IO_SET  = 3'd2;
  localparam logic [2:0] IO_CLR  = 3'd3;
  localparam logic [2:0] IO_EDGE = 3'd4;

  localparam logic [32:0] IO_WORDS = 33'd8;

  // 33-bit operands so base+length never wraps at the top of the address space.
  function automatic logic ranges_overlap(input logic [32:0] a_base, input logic [32:0] a_len,
                                          input logic [32:0] b_base, input logic [32:0] b_len);
    return (a_base < b_base + b_len) && (b_base < a_base + a_len);
  endfunction

endpackage

// File: rtl/mem_map_ctrl_sw_sync_edge.sv
// Two-flop synchroniser for asynchronous switch inputs plus rising-edge detect.
// Synchronised value visible 2 cycles after the input changes; rise pulse follows it.
module sw_sync_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_sw,
  output logic [N-1:0] o_sync,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;
  logic [N-1:0] r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_sync_d <= '0;
    end else begin
      r_meta   <= i_sw;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: decodes CPU accesses into RAM, I/O registers and ROM.
// Reads take MEM_LAT+1 cycles with ready low until rvalid; writes complete at the accepting edge.
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'd0,
  parameter logic [31:0] RAM_WORDS = 32'd27360,
  parameter logic [31:0] IO_BASE   = 32'd27360,
  parameter logic [31:0] ROM_BASE  = 32'd27368,
  parameter logic [31:0] ROM_WORDS = 32'd720,
  parameter int          NSW       = 4,
  parameter int          NGPIO     = 8,
  parameter int          MEM_LAT   = 1,
  parameter logic [31:0] GPIO_RST  = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             ready,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic             err,
  output logic             ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  output logic [31:0]      rom_addr,
  input  logic [31:0]      rom_rdata,
  input  logic [NSW-1:0]   sw_in,
  output logic [NGPIO-1:0] gpio_out
);

  localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + {1'b0, RAM_WORDS};
  localparam logic [32:0] IO_END  = {1'b0, IO_BASE} + IO_WORDS;
  localparam logic [32:0] ROM_END = {1'b0, ROM_BASE} + {1'b0, ROM_WORDS};
  localparam logic [1:0]  LAT     = MEM_LAT[1:0];

  if (ranges_overlap({1'b0, RAM_BASE}, {1'b0, RAM_WORDS}, {1'b0, IO_BASE}, IO_WORDS) ||
      ranges_overlap({1'b0, RAM_BASE}, {1'b0, RAM_WORDS}, {1'b0, ROM_BASE}, {1'b0, ROM_WORDS}) ||
      ranges_overlap({1'b0, IO_BASE}, IO_WORDS, {1'b0, ROM_BASE}, {1'b0, ROM_WORDS})) begin : g_overlap
    $error("mem_map_ctrl: RAM, IO and ROM regions overlap");
  end
  if (NSW < 1 || NSW > 32 || NGPIO < 1 || NGPIO > 32 || MEM_LAT < 1 || MEM_LAT > 3) begin : g_param
    $error("mem_map_ctrl: NSW/NGPIO must be 1..32 and MEM_LAT 1..3");
  end

  function automatic region_t decode(input logic [31:0] a);
    logic [32:0] x;
    x = {1'b0, a};
    if (x >= {1'b0, RAM_BASE} && x < RAM_END) return REG_RAM;
    if (x >= {1'b0, IO_BASE}  && x < IO_END)  return REG_IO;
    if (x >= {1'b0, ROM_BASE} && x < ROM_END) return REG_ROM;
    return REG_NONE;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic            w_done;
  logic [31:0]     r_addr;
  region_t         r_region;
  logic [2:0]      r_ioff;
  logic [31:0]     r_rdata;
  logic            r_rvalid;
  logic            r_err;
  logic [NGPIO-1:0] r_gpio;
  logic [NSW-1:0]  r_edge;

  logic [31:0]     w_addr_eff;
  region_t         w_reg_eff;
  logic [2:0]      w_ioff;
  logic            w_accept, w_wr, w_rd, w_io_wr;
  logic [NSW-1:0]  w_sw_sync, w_sw_rise, w_w1c;
  logic [31:0]     w_rd_dat;

  sw_sync_edge #(.N(NSW)) u_sw_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sw   (sw_in),
    .o_sync (w_sw_sync),
    .o_rise (w_sw_rise)
  );

  // While a read is pending the memories keep seeing the latched address.
  assign w_addr_eff = (r_state == S_WAIT) ? r_addr : addr;
  assign w_reg_eff  = decode(w_addr_eff);
  assign w_ioff     = w_addr_eff[2:0] - IO_BASE[2:0];

  assign ready    = (r_state == S_IDLE) && !r_rvalid;
  assign w_accept = req && ready;
  assign w_wr     = w_accept && we;
  assign w_rd     = w_accept && !we;
  assign w_io_wr  = w_wr && (w_reg_eff == REG_IO);

  assign ram_we    = w_wr && (w_reg_eff == REG_RAM);
  assign ram_addr  = (w_reg_eff == REG_RAM) ? (w_addr_eff - RAM_BASE) : 32'd0;
  assign rom_addr  = (w_reg_eff == REG_ROM) ? (w_addr_eff - ROM_BASE) : 32'd0;
  assign ram_wdata = wdata;

  assign w_w1c = (w_io_wr && w_ioff == IO_EDGE) ? wdata[NSW-1:0] : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rd) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LAT;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == 2'd1) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_dat = '0;
    case (r_region)
      REG_RAM: w_rd_dat = ram_rdata;
      REG_ROM: w_rd_dat = rom_rdata;
      REG_IO: begin
        case (r_ioff)
          IO_SW:   w_rd_dat[NSW-1:0]   = w_sw_sync;
          IO_GPIO: w_rd_dat[NGPIO-1:0] = r_gpio;
          IO_EDGE: w_rd_dat[NSW-1:0]   = r_edge;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_region <= REG_NONE;
      r_ioff   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_done;
      r_err    <= (w_done && r_region == REG_NONE) ||
                  (w_wr && (w_reg_eff == REG_ROM || w_reg_eff == REG_NONE));
      if (w_rd) begin
        r_addr   <= addr;
        r_region <= w_reg_eff;
        r_ioff   <= w_ioff;
      end
      if (w_done) r_rdata <= w_rd_dat;
    end
  end

  // A rising edge in the same cycle as a W1C write keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio <= GPIO_RST[NGPIO-1:0];
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_w1c) | w_sw_rise;
      if (w_io_wr) begin
        case (w_ioff)
          IO_GPIO: r_gpio <= wdata[NGPIO-1:0];
          IO_SET:  r_gpio <= r_gpio | wdata[NGPIO-1:0];
          IO_CLR:  r_gpio <= r_gpio & ~wdata[NGPIO-1:0];
          default: ;
        endcase
      end
    end
  end

  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign err      = r_err;
  assign gpio_out = r_gpio;

endmodule
